// File: rtl/audio_pkg.sv
// Shared audio-path types and constants for the channel strip.
// Used by the highpass, EQ, gain and limiter stages.
//   sample_t   : signed 16-bit audio sample
//   gain_t     : 17-bit unsigned Q1.15 gain, ONE = 32768
//   PHASES     : clocks per audio sample on clk_144
package audio_pkg;

   typedef logic signed [15:0] sample_t;
   typedef logic [16:0]        gain_t;

   localparam gain_t   GAIN_ONE   = 17'd32768;
   localparam sample_t SAMPLE_MAX = 16'sd32767;
   localparam int      PHASES     = 3;

endpackage

// File: rtl/limiter_if.sv
// Sample-stream and control bundle of the limiter stage.
//   enable     : 1 = limiting active, 0 = unity-gain pass-through
//   thresh     : threshold select, T = 32767 >> thresh
//   limiterIn  : signed sample from the highpass stage
//   limiterOut : signed limited sample
//   gainRed    : gain-reduction meter for the UI/LED path
// master = upstream/control side, slave = the limiter itself.
interface limiter_if;
   import audio_pkg::*;

   logic       enable;
   logic [2:0] thresh;
   sample_t    limiterIn;
   sample_t    limiterOut;
   logic [7:0] gainRed;

   modport master (
      output enable,
      output thresh,
      output limiterIn,
      input  limiterOut,
      input  gainRed
   );

   modport slave (
      input  enable,
      input  thresh,
      input  limiterIn,
      output limiterOut,
      output gainRed
   );

endinterface

// File: rtl/sample_phase_ctr.sv
// Free-running mod-PHASES counter marking the clock slots of one audio sample.
//   clk   : sample-rate-multiple clock
//   rst_n : asynchronous active-low reset, phase restarts at 0 on release
//   phase : current slot, 0 .. PHASES-1
module sample_phase_ctr
   import audio_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   output logic [1:0] phase
);

   // Advance the slot every clock, wrapping after the last one.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         phase <= 2'd0;
      end else if (phase == 2'(PHASES - 1)) begin
         phase <= 2'd0;
      end else begin
         phase <= phase + 2'd1;
      end
   end

endmodule

// File: rtl/limiter.sv
// Feedback peak limiter: scales each sample by a smoothed gain that is pulled
// down while the output exceeds the threshold and released back towards unity.
//   clk_144 : system clock, 3 cycles per 48 kHz sample
//   reset_n : asynchronous active-low reset
//   bus     : limiter_if.slave (enable, thresh, limiterIn, limiterOut, gainRed)
// Slot 0 captures the input, slot 1 multiplies, slot 2 publishes the output
// and updates the gain, so the new gain applies from the next sample.
module limiter
   import audio_pkg::*;
#(
   parameter int ATTACK_SHIFT  = 4,
   parameter int RELEASE_SHIFT = 10,
   parameter int GAIN_MIN      = 4096
)(
   input  logic      clk_144,
   input  logic      reset_n,
   limiter_if.slave  bus
);

   logic [1:0] phase;
   sample_t    x_reg;
   sample_t    y_reg;
   sample_t    out_reg;
   gain_t      gain;
   logic [7:0] gain_red;

   sample_t    y_next;
   logic [15:0] mag;
   logic [15:0] thr;
   gain_t      headroom;
   gain_t      gain_dec;
   gain_t      gain_att;
   gain_t      gain_step;
   gain_t      gain_rel;
   gain_t      gain_next;
   logic [9:0] meter_raw;
   logic [7:0] meter_next;

   sample_phase_ctr u_phase (
      .clk   (clk_144),
      .rst_n (reset_n),
      .phase (phase)
   );

   // Datapath: multiply, magnitude, threshold decode and next gain/meter.
   always_comb begin
      // Signed sample times unsigned gain; |result| <= 2^15 because gain <= ONE.
      y_next = 16'((33'(x_reg) * 33'($signed({1'b0, gain}))) >>> 15);

      // |y| with -32768 folded onto 32767 so it never exceeds the top threshold.
      if (y_reg == 16'sh8000) begin
         mag = 16'd32767;
      end else if (y_reg[15]) begin
         mag = 16'(-y_reg);
      end else begin
         mag = 16'(y_reg);
      end

      thr      = $unsigned(SAMPLE_MAX) >> bus.thresh;
      headroom = GAIN_ONE - gain;

      gain_dec = gain - (gain >> ATTACK_SHIFT);
      gain_att = (gain_dec < 17'(GAIN_MIN)) ? 17'(GAIN_MIN) : gain_dec;

      // Minimum step of 1 lets the release land exactly on ONE.
      gain_step = headroom >> RELEASE_SHIFT;
      gain_rel  = gain + ((gain_step == 17'd0) ? 17'd1 : gain_step);

      if (!bus.enable) begin
         gain_next = GAIN_ONE;
      end else if (mag > thr) begin
         gain_next = gain_att;
      end else if (gain < GAIN_ONE) begin
         gain_next = gain_rel;
      end else begin
         gain_next = gain;
      end

      meter_raw  = 10'((GAIN_ONE - gain_next) >> 7);
      meter_next = (meter_raw > 10'd255) ? 8'd255 : meter_raw[7:0];
   end

   // Per-slot register updates of the sample pipeline and gain state.
   always_ff @(posedge clk_144 or negedge reset_n) begin
      if (!reset_n) begin
         x_reg    <= 16'sd0;
         y_reg    <= 16'sd0;
         out_reg  <= 16'sd0;
         gain     <= GAIN_ONE;
         gain_red <= 8'd0;
      end else begin
         case (phase)
            2'd0: begin
               x_reg <= bus.limiterIn;
            end
            2'd1: begin
               y_reg <= y_next;
            end
            2'd2: begin
               out_reg  <= y_reg;
               gain     <= gain_next;
               gain_red <= meter_next;
            end
            default: begin
               x_reg <= x_reg;
            end
         endcase
      end
   end

   assign bus.limiterOut = out_reg;
   assign bus.gainRed    = gain_red;

endmodule

// File: tb/tb_limiter.sv
// Scoreboard bench for the limiter: the stimulus side pushes the expected
// output/meter of every sample it sends; a monitor pops and compares at each
// output slot.
module tb_limiter;
   import audio_pkg::*;

   typedef struct {
      int scen;
      int out;
      int gr;
   } exp_t;

   logic clk_144 = 1'b0;
   logic reset_n = 1'b0;
   limiter_if bus ();

   limiter dut (
      .clk_144 (clk_144),
      .reset_n (reset_n),
      .bus     (bus)
   );

   always #5 clk_144 = ~clk_144;

   int   n_checks   = 0;
   int   n_fail     = 0;
   int   model_gain = 32768;
   exp_t sb[$];
   exp_t mon_e;
   logic [1:0] tb_phase;

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Bench's own view of the sample slot, restarted by reset like the DUT.
   always @(posedge clk_144 or negedge reset_n) begin
      if (!reset_n) tb_phase <= 2'd0;
      else if (tb_phase == 2'd2) tb_phase <= 2'd0;
      else tb_phase <= tb_phase + 2'd1;
   end

   // Monitor: compare outputs just after every output-slot edge.
   always @(posedge clk_144) begin
      if (reset_n && tb_phase == 2'd2) begin
         #1;
         if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_output: got %0d with no pending sample, expected none",
                     $signed(bus.limiterOut));
         end else begin
            mon_e = sb.pop_front();
            check($sformatf("s%0d_out", mon_e.scen), int'($signed(bus.limiterOut)), mon_e.out);
            check($sformatf("s%0d_gainRed", mon_e.scen), int'(bus.gainRed), mon_e.gr);
         end
      end
   end

   // Drive one sample, advance the reference gain and queue the expectation.
   task automatic send(input int scen, input int in_val, input bit en, input int th,
                       input bit use_exp, input int exp_out, input int exp_gr);
      int   y, a, t, step, gr;
      exp_t e;
      bus.limiterIn = 16'(in_val);
      bus.enable    = en;
      bus.thresh    = 3'(th);
      y = int'((longint'(in_val) * longint'(model_gain)) >>> 15);
      a = (y < 0) ? -y : y;
      if (a > 32767) a = 32767;
      t = 32767 >> th;
      if (!en) begin
         model_gain = 32768;
      end else if (a > t) begin
         model_gain = model_gain - (model_gain >> 4);
         if (model_gain < 4096) model_gain = 4096;
      end else if (model_gain < 32768) begin
         step = (32768 - model_gain) >> 10;
         if (step < 1) step = 1;
         model_gain = model_gain + step;
      end
      gr = (32768 - model_gain) >> 7;
      if (gr > 255) gr = 255;
      e.scen = scen;
      e.out  = use_exp ? exp_out : y;
      e.gr   = use_exp ? exp_gr : gr;
      sb.push_back(e);
      repeat (3) @(posedge clk_144);
      #1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got no end of test, expected completion");
      $fatal(1, "timeout");
   end

   initial begin
      bus.enable    = 1'b0;
      bus.thresh    = 3'd0;
      bus.limiterIn = 16'sd0;
      repeat (3) @(posedge clk_144);
      @(negedge clk_144);
      check("reset_out", int'($signed(bus.limiterOut)), 0);
      check("reset_gainRed", int'(bus.gainRed), 0);
      reset_n = 1'b1;

      // 1: below threshold at unity gain
      for (int i = 0; i < 4; i++) send(1, 1000, 1'b1, 3, 1'b1, 1000, 0);

      // 2: step over threshold, gain attacks
      send(2, 16000, 1'b1, 3, 1'b1, 16000, 16);
      send(2, 16000, 1'b1, 3, 1'b1, 15000, 31);
      for (int i = 0; i < 40; i++) send(2, 16000, 1'b1, 3, 1'b0, 0, 0);

      // 3: release all the way back to unity
      for (int i = 0; i < 6500; i++) send(3, 1000, 1'b1, 3, 1'b0, 0, 0);
      send(3, 1000, 1'b1, 3, 1'b1, 1000, 0);
      send(3, 1000, 1'b1, 3, 1'b1, 1000, 0);

      // 4: full-scale negative at top threshold is not over
      for (int i = 0; i < 3; i++) send(4, -32768, 1'b1, 0, 1'b1, -32768, 0);

      // 5: bypass, then enable starts limiting on the following sample
      send(5, 32767, 1'b0, 7, 1'b1, 32767, 0);
      send(5, 32767, 1'b0, 7, 1'b1, 32767, 0);
      send(5, 32767, 1'b1, 7, 1'b1, 32767, 16);
      send(5, 32767, 1'b1, 7, 1'b1, 30719, 31);

      // 6: asynchronous reset in the middle of slot 1 with gain below unity
      bus.limiterIn = 16'sd5000;
      @(posedge clk_144);
      #3;
      reset_n = 1'b0;
      #1;
      check("s6_async_out", int'($signed(bus.limiterOut)), 0);
      check("s6_async_gainRed", int'(bus.gainRed), 0);
      model_gain = 32768;
      @(negedge clk_144);
      @(negedge clk_144);
      reset_n = 1'b1;
      send(6, 5000, 1'b1, 7, 1'b1, 5000, 16);
      send(6, 5000, 1'b1, 7, 1'b1, 4687, 31);

      @(negedge clk_144);
      check("pending_expectations", sb.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
